mask_downsampler: RTL and testbench
===================================

Name: mask_downsampler

Overview:
- Sits directly upstream of the k-means centroid stage.
- Takes the full-resolution 1-bit colour-threshold mask stream (1280x720, raster order, driven by hcount/vcount) and reduces it to the 320x180 mask grid by 4x4 block voting.
- Emits one mask bit per output pixel with its (x,y) coordinates, plus a one-cycle end-of-frame pulse that starts the k-means update pass.

Parameters:
- IN_WIDTH, 1280, active input columns.
- IN_HEIGHT, 720, active input rows.
- THRESH, 8, minimum set pixels (1..16) in a 4x4 block for mask_out=1.
- Scale factor is fixed at 4; OUT_WIDTH=IN_WIDTH/4 and OUT_HEIGHT=IN_HEIGHT/4 are derived.

Ports:
- clk_in  input  1  system clock; all logic in this single domain.
- rst_n_in  input  1  asynchronous, active-low reset.
- hcount_in  input  11  input column; values >= IN_WIDTH are blanking.
- vcount_in  input  10  input row; values >= IN_HEIGHT are blanking.
- pixel_mask_in  input  1  threshold result for the current pixel.
- pixel_valid_in  input  1  qualifies pixel_mask_in; when low, the pixel contributes 0.
- x_out  output  9  output column 0..319.
- y_out  output  8  output row 0..179.
- mask_out  output  1  block vote result.
- valid_out  output  1  one-cycle strobe; x_out, y_out and mask_out are valid with it.
- new_frame_out  output  1  one-cycle pulse after the last block of a frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state WAIT_SOF; row accumulator 0. Column buffer contents are don't-care.
- Active pixel: hcount_in < IN_WIDTH and vcount_in < IN_HEIGHT. Contribution c = pixel_mask_in & pixel_valid_in. The coordinate stream advances every cycle whether or not pixel_valid_in is high.
- States:
  - WAIT_SOF: ignore input until an active pixel at (0,0), then go to ACTIVE and process that pixel.
  - ACTIVE: normal operation.
  - Go from ACTIVE back to WAIT_SOF the cycle after block (319,179) is emitted.
- Row accumulator (3 bits): when hcount_in[1:0]==0, load c; otherwise add c.
- Column buffer: 320 x 5 bits, indexed by hcount_in>>2. Updated on active pixels with hcount_in[1:0]==3. Let s = row_acc + c (0..4):
  - vcount_in[1:0]==0: write s (overwrite; no clear pass needed).
  - vcount_in[1:0]==1 or 2: write buffer + s.
  - vcount_in[1:0]==3: emit only, total = buffer + s (0..16).
- Emission: registered, exactly 1 cycle after the corner input pixel.
  - valid_out=1, x_out=hcount_in>>2, y_out=vcount_in>>2, mask_out=(total >= THRESH).
  - Outputs are produced in raster order, at most one per 4 input cycles.
- new_frame_out: pulses 1 cycle after the valid_out for (319,179), i.e. 2 cycles after input pixel (1279,719).
- Blanking pixels: no state change and no output.
- An active (0,0) seen while ACTIVE (truncated frame): restart silently. No new_frame_out for the aborted frame. The overwrite on rows with vcount[1:0]==0 guarantees no stale counts.
- Reset asserted mid-frame: outputs drop to 0 immediately (async); the block waits for the next (0,0).
- Total uses 5-bit arithmetic; no saturation is needed (maximum 16).

Optional Feature:
- Macro MASK_DOWNSAMPLER_STATS_EN. When defined:
  - Adds output port ones_count_out [16:0]: the count of mask_out==1 emissions in the last completed frame.
  - It updates in the same cycle as new_frame_out and resets to 0.
  - The internal counter clears when new_frame_out fires and on restart.
- Without the macro: no port, no counter.

Decomposition:
- Shared package mask_pkg: IN_WIDTH/IN_HEIGHT/OUT_WIDTH/OUT_HEIGHT constants, the coordinate typedefs (x_t 9-bit, y_t 8-bit), and the state enum.
- One natural sub-module: mask_col_buffer, the 320x5 single-clock read-modify-write store with combinational read and synchronous write.

Test Plan:
- All-ones full frame, THRESH=8 -> 57600 valid_out strobes, all mask_out=1, raster order. new_frame_out arrives 2 cycles after (1279,719). ones_count_out=57600 with the feature enabled.
- Single 4x4 block at input (40..43, 8..11) with exactly 8 set pixels; all others 0 -> only block (10,2) has mask_out=1. With 7 set pixels, no block has mask_out=1.
- pixel_valid_in=0 on the entire frame with pixel_mask_in=1 -> all mask_out=0, and 57600 strobes still emitted.
- Frame aborted at row 400 and restarted at (0,0) -> no new_frame_out for the aborted frame. The next full frame produces correct results, with no residue from the aborted partial rows.
- rst_n_in pulsed low mid-emission -> valid_out and new_frame_out go low asynchronously. No output appears until the next (0,0); the following frame is correct.
- Blanking coordinates (hcount 1280..1649) interleaved with active pixels -> no strobes during blanking, and block counts are unaffected.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared constants, coordinate types and control states for the mask downsampler.
package mask_pkg;

  localparam int IN_WIDTH   = 1280;
  localparam int IN_HEIGHT  = 720;
  localparam int OUT_WIDTH  = IN_WIDTH / 4;
  localparam int OUT_HEIGHT = IN_HEIGHT / 4;
  localparam int THRESH_DEF = 8;

  typedef logic [8:0] x_t;
  typedef logic [7:0] y_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/mask_downsampler_if.sv
// Pixel-in / block-out bus of the mask downsampler.
// MASK_DOWNSAMPLER_STATS_EN adds the per-frame ones_count_out statistic.
interface mask_downsampler_if;
  import mask_pkg::*;

  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        pixel_mask_in;
  logic        pixel_valid_in;
  x_t          x_out;
  y_t          y_out;
  logic        mask_out;
  logic        valid_out;
  logic        new_frame_out;
`ifdef MASK_DOWNSAMPLER_STATS_EN
  logic [16:0] ones_count_out;
`endif

  modport master (
    output hcount_in, vcount_in, pixel_mask_in, pixel_valid_in,
    input  x_out, y_out, mask_out, valid_out, new_frame_out
`ifdef MASK_DOWNSAMPLER_STATS_EN
    , input ones_count_out
`endif
  );

  modport slave (
    input  hcount_in, vcount_in, pixel_mask_in, pixel_valid_in,
    output x_out, y_out, mask_out, valid_out, new_frame_out
`ifdef MASK_DOWNSAMPLER_STATS_EN
    , output ones_count_out
`endif
  );

endinterface

// File: rtl/mask_col_buffer.sv
// Per-output-column partial block counts: combinational read, synchronous write.
module mask_col_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mask_downsampler.sv
// 4x4 block-vote downsampler for the 1-bit threshold mask stream.
// Optional MASK_DOWNSAMPLER_STATS_EN reports mask_out==1 emissions per completed frame.
module mask_downsampler #(
  parameter int IN_WIDTH  = mask_pkg::IN_WIDTH,
  parameter int IN_HEIGHT = mask_pkg::IN_HEIGHT,
  parameter int THRESH    = mask_pkg::THRESH_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  mask_downsampler_if.slave bus
);
  import mask_pkg::*;

  localparam int OUT_W = IN_WIDTH / 4;
  localparam int OUT_H = IN_HEIGHT / 4;
  localparam int AW    = $clog2(OUT_W);

  state_t      state;
  logic [2:0]  row_acc;
  logic        done;
  logic        active_pix, sof, proc, emit, last_blk, hit, c, col_we;
  logic [2:0]  s;
  logic [4:0]  col_rd, col_wr, total;
  x_t          col_idx;
  y_t          row_idx;
`ifdef MASK_DOWNSAMPLER_STATS_EN
  logic [16:0] ones_cnt;
`endif

  assign active_pix = (int'(bus.hcount_in) < IN_WIDTH) && (int'(bus.vcount_in) < IN_HEIGHT);
  assign sof        = active_pix && (bus.hcount_in == '0) && (bus.vcount_in == '0);
  // A (0,0) pixel is processed in either state, which also makes a truncated frame restart cleanly.
  assign proc       = active_pix && ((state == ACTIVE) || sof);
  assign c          = bus.pixel_mask_in & bus.pixel_valid_in;
  assign col_idx    = bus.hcount_in[10:2];
  assign row_idx    = bus.vcount_in[9:2];
  assign s          = row_acc + {2'b00, c};
  assign total      = col_rd + {2'b00, s};
  // First row of a block band overwrites, so stale counts never survive into a new band.
  assign col_wr     = (bus.vcount_in[1:0] == 2'd0) ? {2'b00, s} : total;
  assign col_we     = proc && (bus.hcount_in[1:0] == 2'd3) && (bus.vcount_in[1:0] != 2'd3);
  assign emit       = proc && (bus.hcount_in[1:0] == 2'd3) && (bus.vcount_in[1:0] == 2'd3);
  assign last_blk   = (col_idx == x_t'(OUT_W - 1)) && (row_idx == y_t'(OUT_H - 1));
  assign hit        = total >= 5'(THRESH);

  mask_col_buffer #(
    .DEPTH (OUT_W),
    .WIDTH (5),
    .AW    (AW)
  ) u_col_buf (
    .clk     (clk_in),
    .we      (col_we),
    .wr_addr (col_idx[AW-1:0]),
    .wr_data (col_wr),
    .rd_addr (col_idx[AW-1:0]),
    .rd_data (col_rd)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= WAIT_SOF;
      row_acc           <= '0;
      done              <= 1'b0;
      bus.valid_out     <= 1'b0;
      bus.x_out         <= '0;
      bus.y_out         <= '0;
      bus.mask_out      <= 1'b0;
      bus.new_frame_out <= 1'b0;
`ifdef MASK_DOWNSAMPLER_STATS_EN
      ones_cnt           <= '0;
      bus.ones_count_out <= '0;
`endif
    end else begin
      bus.valid_out     <= emit;
      done              <= emit && last_blk;
      bus.new_frame_out <= done;

      if (proc) row_acc <= (bus.hcount_in[1:0] == 2'd0) ? {2'b00, c} : s;

      if (emit) begin
        bus.x_out    <= col_idx;
        bus.y_out    <= row_idx;
        bus.mask_out <= hit;
      end

      if (sof)       state <= ACTIVE;
      else if (done) state <= WAIT_SOF;

`ifdef MASK_DOWNSAMPLER_STATS_EN
      if (done) begin
        bus.ones_count_out <= ones_cnt;
        ones_cnt           <= '0;
      end else if (sof) begin
        ones_cnt <= '0;
      end else if (emit && hit) begin
        ones_cnt <= ones_cnt + 17'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mask_downsampler.sv
// Self-checking bench for mask_downsampler on a reduced 64x16 frame with a block-count reference model.
module tb_mask_downsampler;
  localparam int W  = 64;
  localparam int H  = 16;
  localparam int HB = 8;
  localparam int TH = 8;
  localparam int OW = W / 4;
  localparam int OH = H / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  int   exp_ones = 0;
  bit   img [H][W];
  bit   vld [H][W];
  logic [17:0] exp_q [$];
  logic [17:0] obs_q [$];
  int   nf_q [$];

  mask_downsampler_if bus ();

  mask_downsampler #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H),
    .THRESH    (TH)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) obs_q.push_back({bus.x_out, bus.y_out, bus.mask_out});
    if (bus.new_frame_out === 1'b1) nf_q.push_back(cyc);
  end

  task automatic drive_pix(input int h, input int v, input bit m, input bit vl);
    @(posedge clk);
    #1;
    bus.hcount_in      = h[10:0];
    bus.vcount_in      = v[9:0];
    bus.pixel_mask_in  = m;
    bus.pixel_valid_in = vl;
    if (h == W - 1 && v == H - 1) last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_pix(W, H, 1'b0, 1'b0);
  endtask

  // Rows y0..y1-1 with horizontal blanking; rows >= H are vertical blanking with random data.
  task automatic drive_rows(input int y0, input int y1, input bit ilv);
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < W + HB; x++) begin
        if (ilv && x < W && $urandom_range(0, 3) == 0)
          drive_pix(int'($urandom_range(W, 2047)), y, 1'b1, 1'b1);
        if (x < W && y < H) drive_pix(x, y, img[y][x], vld[y][x]);
        else drive_pix(x, y, 1'($urandom), 1'($urandom));
      end
    end
  endtask

  task automatic fill(input int pct_mask, input int pct_vld);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img[y][x] = ($urandom_range(0, 99) < pct_mask);
        vld[y][x] = ($urandom_range(0, 99) < pct_vld);
      end
  endtask

  // Reference: count qualified set pixels in each 4x4 block, raster order.
  function automatic void build_exp(input int brows);
    exp_q.delete();
    exp_ones = 0;
    for (int by = 0; by < brows; by++)
      for (int bx = 0; bx < OW; bx++) begin
        int n;
        logic [8:0] xx;
        logic [7:0] yy;
        n  = 0;
        xx = 9'(bx);
        yy = 8'(by);
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            n += int'(img[by*4+dy][bx*4+dx] & vld[by*4+dy][bx*4+dx]);
        exp_q.push_back({xx, yy, n >= TH});
        if (n >= TH) exp_ones++;
      end
  endfunction

  task automatic run_frame(input bit ilv);
    obs_q.delete();
    nf_q.delete();
    drive_rows(0, H + 2, ilv);
    idle(4);
  endtask

  task automatic test_reset();
    bus.hcount_in = 11'(W); bus.vcount_in = 10'(H);
    bus.pixel_mask_in = 1'b0; bus.pixel_valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b want 0", bus.valid_out); end
    checks++; if (bus.new_frame_out !== 1'b0) begin errors++; $display("FAIL reset new_frame_out: got %b want 0", bus.new_frame_out); end
    checks++; if (bus.mask_out !== 1'b0) begin errors++; $display("FAIL reset mask_out: got %b want 0", bus.mask_out); end
    checks++; if (bus.x_out !== 9'd0 || bus.y_out !== 8'd0) begin errors++; $display("FAIL reset coords: got (%0d,%0d) want (0,0)", bus.x_out, bus.y_out); end
`ifdef MASK_DOWNSAMPLER_STATS_EN
    checks++; if (bus.ones_count_out !== 17'd0) begin errors++; $display("FAIL reset ones_count: got %0d want 0", bus.ones_count_out); end
`endif
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset idle strobes: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_all_ones();
    int bad;
    fill(100, 100);
    build_exp(OH);
    run_frame(1'b0);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_q[i][0] !== 1'b1) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != OW * OH) begin
      errors++; $display("FAIL all_ones blocks: %0d wrong, strobes got %0d want %0d", bad, obs_q.size(), OW * OH);
    end
    checks++;
    if (nf_q.size() != 1 || nf_q[0] != last_cyc + 2) begin
      errors++; $display("FAIL all_ones new_frame: pulses %0d first at %0d, want 1 at %0d", nf_q.size(), (nf_q.size() == 0) ? -1 : nf_q[0], last_cyc + 2);
    end
`ifdef MASK_DOWNSAMPLER_STATS_EN
    checks++; if (bus.ones_count_out !== 17'(OW * OH)) begin errors++; $display("FAIL all_ones ones_count: got %0d want %0d", bus.ones_count_out, OW * OH); end
`endif
  endtask

  task automatic test_single_block(input int k);
    int bad, n, ones, at_target;
    fill(0, 100);
    n = 0;
    while (n < k) begin
      int p;
      p = int'($urandom_range(0, 15));
      if (!img[8 + p / 4][40 + p % 4]) begin
        img[8 + p / 4][40 + p % 4] = 1'b1;
        n++;
      end
    end
    build_exp(OH);
    run_frame(1'b0);
    bad = 0; ones = 0; at_target = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    foreach (obs_q[i]) if (obs_q[i][0] === 1'b1) begin
      ones++;
      if (obs_q[i][17:1] === {9'd10, 8'd2}) at_target++;
    end
    checks++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_block_%0d blocks: %0d wrong, strobes got %0d want %0d", k, bad, obs_q.size(), exp_q.size());
    end
    checks++;
    if (ones != ((k >= TH) ? 1 : 0) || at_target != ones) begin
      errors++; $display("FAIL single_block_%0d ones: got %0d (at (10,2): %0d) want %0d", k, ones, at_target, (k >= TH) ? 1 : 0);
    end
  endtask

  task automatic test_valid_low();
    int ones;
    fill(100, 0);
    run_frame(1'b0);
    ones = 0;
    foreach (obs_q[i]) if (obs_q[i][0] !== 1'b0) ones++;
    checks++;
    if (ones != 0 || obs_q.size() != OW * OH) begin
      errors++; $display("FAIL valid_low: ones got %0d want 0, strobes got %0d want %0d", ones, obs_q.size(), OW * OH);
    end
  endtask

  task automatic test_random_blanking();
    for (int f = 0; f < 3; f++) begin
      int bad;
      fill(int'($urandom_range(20, 80)), 80);
      build_exp(OH);
      run_frame(1'b1);
      bad = 0;
      foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0 || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL random_blank_%0d blocks: %0d wrong, strobes got %0d want %0d", f, bad, obs_q.size(), exp_q.size());
      end
      checks++;
      if (nf_q.size() != 1 || nf_q[0] != last_cyc + 2) begin
        errors++; $display("FAIL random_blank_%0d new_frame: pulses %0d, want 1 at %0d", f, nf_q.size(), last_cyc + 2);
      end
`ifdef MASK_DOWNSAMPLER_STATS_EN
      checks++; if (bus.ones_count_out !== 17'(exp_ones)) begin errors++; $display("FAIL random_blank_%0d ones_count: got %0d want %0d", f, bus.ones_count_out, exp_ones); end
`endif
    end
  endtask

  task automatic test_abort();
    int bad;
    fill(50, 90);
    build_exp(2);
    obs_q.delete();
    nf_q.delete();
    drive_rows(0, 9, 1'b0);
    for (int x = 0; x < W / 2; x++) drive_pix(x, 9, img[9][x], vld[9][x]);
    idle(3);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort partial: %0d wrong, strobes got %0d want %0d", bad, obs_q.size(), exp_q.size());
    end
    checks++; if (nf_q.size() != 0) begin errors++; $display("FAIL abort new_frame: pulses got %0d want 0", nf_q.size()); end
    fill(50, 90);
    build_exp(OH);
    run_frame(1'b0);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort restart: %0d wrong, strobes got %0d want %0d", bad, obs_q.size(), exp_q.size());
    end
    checks++; if (nf_q.size() != 1) begin errors++; $display("FAIL abort restart new_frame: pulses got %0d want 1", nf_q.size()); end
  endtask

  task automatic test_reset_mid();
    int bad;
    fill(50, 90);
    drive_rows(0, 7, 1'b0);
    for (int x = 0; x < W; x++) drive_pix(x, 7, img[7][x], vld[7][x]);
    drive_pix(W, 7, 1'b0, 1'b0);
    #1;
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL reset_mid strobe before: got %b want 1", bus.valid_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0 || bus.new_frame_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid async drop: valid %b new_frame %b want 0 0", bus.valid_out, bus.new_frame_out);
    end
    checks++; if (bus.x_out !== 9'd0) begin errors++; $display("FAIL reset_mid x_out: got %0d want 0", bus.x_out); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    obs_q.delete();
    nf_q.delete();
    drive_rows(8, H + 2, 1'b0);
    idle(3);
    checks++; if (obs_q.size() != 0 || nf_q.size() != 0) begin
      errors++; $display("FAIL reset_mid wait_sof: strobes %0d pulses %0d want 0 0", obs_q.size(), nf_q.size());
    end
    fill(50, 90);
    build_exp(OH);
    run_frame(1'b0);
    bad = 0;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != exp_q.size() || nf_q.size() != 1) begin
      errors++; $display("FAIL reset_mid next frame: %0d wrong, strobes got %0d want %0d, pulses %0d", bad, obs_q.size(), exp_q.size(), nf_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_block(8);
    test_single_block(7);
    test_valid_low();
    test_random_blanking();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
